lfsr_cipher_ctrl: RTL
=====================

Name: lfsr_cipher_ctrl

Overview:
Sequencing controller for the top-level LFSR stream encrypter. It accepts seed configuration bytes and plaintext bytes over valid/ready handshakes. For each byte it clocks a 16-bit Galois LFSR eight times to build a keystream byte, XORs that with the plaintext, and presents the ciphertext on an output handshake. It sits between the top-level pin mapping (ui_in/uio/uo_out) and the LFSR datapath, and owns all stepping, loading and lock-up recovery.

Parameters:
WIDTH, 16, LFSR state width
TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1)
DEFAULT_SEED, 16'hACE1, state substituted when a byte is accepted with state == 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  seed byte write request
cfg_sel  in  1  0 = write state[7:0], 1 = write state[15:8]
cfg_data  in  8  seed byte
cfg_ready  out  1  config write accepted this cycle when cfg_valid & cfg_ready
bypass  in  1  sampled at byte accept; 1 = pass plaintext unencrypted, LFSR still steps
in_valid  in  1  plaintext byte valid
in_data  in  8  plaintext byte
in_ready  out  1  controller can accept a byte
out_valid  out  1  ciphertext valid
out_data  out  8  ciphertext byte
out_ready  in  1  downstream accepts ciphertext
busy  out  1  high in STEP and DONE
lfsr_state  out  16  current LFSR state, for debug and observation

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, i.e. sampled only on rising clk.
- Reset values: state = IDLE, lfsr = DEFAULT_SEED, step count = 0, out_valid = 0, out_data = 0, busy = 0. in_ready and cfg_ready are 1 in the first cycle after reset.
- FSM states: IDLE, STEP, DONE.
- IDLE:
  - in_ready = 1 and cfg_ready = 1.
  - If cfg_valid and in_valid are both high in the same cycle, the config write takes priority and in_ready is forced to 0 that cycle.
  - Config write: replaces the selected byte of lfsr. Takes effect the next cycle. No other state change.
  - Byte accept (in_valid & in_ready): latch in_data and bypass, clear the keystream accumulator, count = 0, go to STEP. If lfsr == 0 at accept, load DEFAULT_SEED instead.
- STEP: one LFSR step per cycle.
  - Keystream bit = lfsr[0] before the shift.
  - lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
  - The bit is written to ks[count], so the keystream byte is assembled LSB-first.
  - After count 7 (8 steps): out_data <= bypass ? pt : pt ^ ks, out_valid <= 1, go to DONE.
- DONE:
  - Hold out_valid and out_data stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - out_ready is ignored in other states.
- Latency: out_valid rises 8 cycles after the accept edge. Minimum throughput is one byte per 10 cycles.
- cfg_ready = 0 and in_ready = 0 outside IDLE. Config attempted mid-byte is not accepted; the requester holds cfg_valid.
- rst asserted mid-byte aborts it immediately. The pending ciphertext is discarded and lfsr returns to DEFAULT_SEED.
- A zero state is never stepped: lock-up recovery happens only at accept. A zero written via config is visible on lfsr_state until then.
- Decryption is the same operation with the same seed. The controller has no mode for it.

Decomposition:
- Package lfsr_pkg:
  - WIDTH, TAPS and DEFAULT_SEED defaults
  - enum ctrl_state_t {IDLE, STEP, DONE}
  - CFG_SEL_LO / CFG_SEL_HI constants
- Sub-module lfsr_core: holds the state register and exposes step, load/load_value, byte-write port and the keystream bit (lfsr[0]). The controller holds the FSM, counter, accumulator, plaintext and output registers.

Test Plan:
- Reset, then seed 0x0001 (cfg lo = 0x01, hi = 0x00), then plaintext 0x00 -> out_data = 0x01 exactly 8 cycles after accept, lfsr_state = 0x0168.
- Continue with plaintext 0xFF -> out_data = 0x97 (keystream 0x68), lfsr_state = 0x7C41. Reseed 0x0001 and feed 0x01, then 0x97 -> outputs 0x00, then 0xFF (decrypt round-trip).
- Write seed 0x0000, accept plaintext 0x00 -> LFSR starts from 0xACE1. Output equals the result from a direct 0xACE1 seed, and is never 0x00-state lock-up.
- Hold out_ready = 0 for 20 cycles in DONE -> out_valid and out_data stable, in_ready = 0, cfg_ready = 0, cfg writes ignored. Release -> IDLE next cycle.
- cfg_valid and in_valid together in IDLE -> config applied, byte not accepted until the following cycle. bypass = 1 with 0x5A -> out_data = 0x5A and the LFSR still advances 8 steps.
- rst pulsed at step 4 -> out_valid = 0, lfsr_state = 0xACE1, in_ready = 1 the next cycle.

Source files
------------

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Purpose  : Shared definitions for the LFSR stream-cipher controller.
//            Holds the default LFSR geometry, the controller state encoding
//            and the byte-select encoding used by the seed write port.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package lfsr_pkg;

  // Default LFSR geometry: x^16 + x^14 + x^13 + x^11 + 1, right-shifting
  // Galois form, so the feedback mask lives in the top bits.
  localparam int          LFSR_WIDTH_DEF   = 16;
  localparam logic [15:0] LFSR_TAPS_DEF    = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF    = 16'hACE1;

  // Steps per keystream byte.
  localparam int          STEPS_PER_BYTE   = 8;

  // Seed byte select.
  localparam logic        CFG_SEL_LO       = 1'b0;
  localparam logic        CFG_SEL_HI       = 1'b1;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_core
// Purpose  : Galois LFSR state register. Supports a whole-state load, a
//            single right-shift step and a byte-wide write into either the
//            low or high byte of the state.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            step           - advance the LFSR one position this cycle
//            load           - replace the whole state with load_value
//            load_value     - state to load
//            wr_en          - byte write strobe
//            wr_sel         - 0 = state[7:0], 1 = state[15:8]
//            wr_data        - byte to write
//            state          - current LFSR state
//            ks_bit         - keystream bit (state[0], before the shift)
// Revision : 1.0  initial release
// ============================================================================
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = LFSR_WIDTH_DEF,
  parameter logic [WIDTH-1:0] TAPS         = LFSR_TAPS_DEF,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [7:0]       wr_data,
  output logic [WIDTH-1:0] state,
  output logic             ks_bit
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;

  // Right shift; the bit falling out of position 0 selects the feedback mask.
  always_comb begin
    w_next = (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
  end

  // Load has priority over step, step over byte write. The controller never
  // asserts more than one of these in the same cycle; the ordering only makes
  // the behaviour well defined if it ever did.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DEFAULT_SEED;
    end else if (load) begin
      r_state <= load_value;
    end else if (step) begin
      r_state <= w_next;
    end else if (wr_en) begin
      if (wr_sel == CFG_SEL_LO) begin
        r_state[7:0] <= wr_data;
      end else begin
        r_state[WIDTH-1 -: 8] <= wr_data;
      end
    end
  end

  assign state  = r_state;
  assign ks_bit = r_state[0];

endmodule : lfsr_core
`default_nettype wire

// File: rtl/lfsr_cipher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_cipher_ctrl
// Purpose  : Byte-level sequencer for the LFSR stream encrypter. Accepts seed
//            bytes and plaintext bytes over valid/ready, steps the LFSR eight
//            times per byte to build an LSB-first keystream byte, and offers
//            plaintext ^ keystream (or plaintext alone in bypass) on an output
//            valid/ready handshake. Recovers from an all-zero state at byte
//            accept by substituting DEFAULT_SEED.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            cfg_valid/cfg_ready  - seed byte write handshake
//            cfg_sel, cfg_data    - byte select (0 lo / 1 hi) and seed byte
//            bypass               - pass plaintext through (sampled at accept)
//            in_valid/in_ready    - plaintext handshake, in_data byte
//            out_valid/out_ready  - ciphertext handshake, out_data byte
//            busy                 - high while stepping or holding a result
//            lfsr_state           - live LFSR state for observation
// Revision : 1.0  initial release
// ============================================================================
module lfsr_cipher_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = LFSR_WIDTH_DEF,
  parameter logic [WIDTH-1:0] TAPS         = LFSR_TAPS_DEF,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic             cfg_sel,
  input  logic [7:0]       cfg_data,
  output logic             cfg_ready,
  input  logic             bypass,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [WIDTH-1:0] lfsr_state
);

  ctrl_state_t      r_state;
  logic [2:0]       r_count;
  logic [7:0]       r_ks;
  logic [7:0]       r_pt;
  logic             r_bypass;
  logic             r_out_valid;
  logic [7:0]       r_out_data;

  logic             w_idle;
  logic             w_cfg_accept;
  logic             w_byte_accept;
  logic             w_step;
  logic             w_lockup;
  logic             w_ks_bit;
  logic [WIDTH-1:0] w_lfsr;
  logic [7:0]       w_ks_full;

  // --------------------------------------------------------------------------
  // Handshake decode. A config write and a byte arriving together resolve in
  // favour of the config write; the byte waits one cycle and is then accepted
  // against the freshly written seed.
  // --------------------------------------------------------------------------
  always_comb begin
    w_idle        = (r_state == IDLE);
    cfg_ready     = w_idle;
    in_ready      = w_idle & ~cfg_valid;
    w_cfg_accept  = cfg_valid & cfg_ready;
    w_byte_accept = in_valid & in_ready;
    w_step        = (r_state == STEP);
    // An all-zero Galois LFSR never leaves zero, so it is reseeded here,
    // at byte accept, and nowhere else.
    w_lockup      = w_byte_accept & (w_lfsr == '0);
  end

  // On the final step the eighth keystream bit is still on the core output
  // and not yet in the accumulator, so splice it in directly.
  always_comb begin
    w_ks_full = {w_ks_bit, r_ks[6:0]};
  end

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .step       (w_step),
    .load       (w_lockup),
    .load_value (DEFAULT_SEED),
    .wr_en      (w_cfg_accept),
    .wr_sel     (cfg_sel),
    .wr_data    (cfg_data),
    .state      (w_lfsr),
    .ks_bit     (w_ks_bit)
  );

  // --------------------------------------------------------------------------
  // Sequencer: IDLE -> STEP (8 cycles) -> DONE -> IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= 3'd0;
      r_ks        <= 8'h00;
      r_pt        <= 8'h00;
      r_bypass    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_byte_accept) begin
            r_pt     <= in_data;
            r_bypass <= bypass;
            r_ks     <= 8'h00;
            r_count  <= 3'd0;
            r_state  <= STEP;
          end
        end

        STEP: begin
          r_ks[r_count] <= w_ks_bit;
          r_count       <= r_count + 3'd1;
          if (r_count == 3'(STEPS_PER_BYTE - 1)) begin
            r_out_data  <= r_bypass ? r_pt : (r_pt ^ w_ks_full);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end

        DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = ~w_idle;
  assign lfsr_state = w_lfsr;

endmodule : lfsr_cipher_ctrl
`default_nettype wire
